// File: rtl/aes_core_driver_if.sv
// -----------------------------------------------------------------------------
// aes_core_driver_if
// Client-facing request/response channel of aes_core_driver.
//   cmd_*  : request (valid/ready), carrying key, keylen, encdec and block.
//   rsp_*  : response (valid/ready), carrying the result block and a flag
//            marking a watchdog abort.
// Modports:
//   master : the client (bus/DMA front-end) that issues requests.
//   slave  : the driver that serves them.
// -----------------------------------------------------------------------------
interface aes_core_driver_if;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [255:0] cmd_key;
  logic         cmd_keylen;
  logic         cmd_encdec;
  logic [127:0] cmd_block;

  logic         rsp_valid;
  logic         rsp_ready;
  logic [127:0] rsp_data;
  logic         rsp_timeout;

  modport master (
    output cmd_valid, cmd_key, cmd_keylen, cmd_encdec, cmd_block, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_timeout
  );

  modport slave (
    input  cmd_valid, cmd_key, cmd_keylen, cmd_encdec, cmd_block, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_timeout
  );
endinterface

// File: rtl/aes_core_driver.sv
// -----------------------------------------------------------------------------
// aes_core_driver
// Command-side initiator for a single aes_core. Accepts one block request,
// runs the core's init/next pulse protocol, and returns the result. The last
// expanded key is remembered so a repeated key (same key and keylen) skips the
// init phase. A watchdog bounds every pulse/wait state; on expiry the request
// is answered with rsp_timeout=1, rsp_data=0 and the key cache is dropped.
//
// Ports:
//   clk, reset_n        : clock (rising edge), asynchronous active-low reset
//   bus (slave)         : cmd_* request channel and rsp_* response channel
//   core_init/core_next : one-cycle pulses to the core
//   core_key/keylen/encdec/block : command fields held to the core
//   core_ready, core_result, core_result_valid : core status and result
// All outputs are registered.
// -----------------------------------------------------------------------------
module aes_core_driver #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic          clk,
  input  logic          reset_n,
  aes_core_driver_if.slave bus,
  output logic          core_init,
  output logic          core_next,
  output logic [255:0]  core_key,
  output logic          core_keylen,
  output logic          core_encdec,
  output logic [127:0]  core_block,
  input  logic          core_ready,
  input  logic [127:0]  core_result,
  input  logic          core_result_valid
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] WD_MAX  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT_PULSE,
    S_INIT_WAIT,
    S_NEXT_PULSE,
    S_NEXT_WAIT,
    S_RESP
  } state_e;

  state_e             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_wdog, w_wdog_nxt;
  logic               r_key_cached, w_key_cached_nxt;
  logic [255:0]       r_cached_key, w_cached_key_nxt;
  logic               r_cached_keylen, w_cached_keylen_nxt;

  logic               r_cmd_ready, w_cmd_ready_nxt;
  logic               r_core_init, w_core_init_nxt;
  logic               r_core_next, w_core_next_nxt;
  logic [255:0]       r_core_key, w_core_key_nxt;
  logic               r_core_keylen, w_core_keylen_nxt;
  logic               r_core_encdec, w_core_encdec_nxt;
  logic [127:0]       r_core_block, w_core_block_nxt;
  logic               r_rsp_valid, w_rsp_valid_nxt;
  logic [127:0]       r_rsp_data, w_rsp_data_nxt;
  logic               r_rsp_timeout, w_rsp_timeout_nxt;

  logic w_accept, w_hit, w_pulse_inflight, w_expire, w_result, w_timeout;

  // cmd_ready is only ever high in IDLE, so this is the accept condition.
  assign w_accept = bus.cmd_valid & r_cmd_ready;
  assign w_hit    = r_key_cached && (bus.cmd_key == r_cached_key) &&
                    (bus.cmd_keylen == r_cached_keylen);
  // The cycle in which a pulse is on the wire: the core has not yet seen it
  // and core_ready still shows the pre-pulse idle value, so it is ignored.
  assign w_pulse_inflight = r_core_init | r_core_next;
  assign w_expire = (r_wdog >= WD_LAST);
  assign w_result = (r_state == S_NEXT_WAIT) && !w_pulse_inflight &&
                    core_ready && core_result_valid;

  // State and output registers.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state         <= S_IDLE;
      r_wdog          <= '0;
      r_key_cached    <= 1'b0;
      r_cached_key    <= '0;
      r_cached_keylen <= 1'b0;
      r_cmd_ready     <= 1'b0;
      r_core_init     <= 1'b0;
      r_core_next     <= 1'b0;
      r_core_key      <= '0;
      r_core_keylen   <= 1'b0;
      r_core_encdec   <= 1'b0;
      r_core_block    <= '0;
      r_rsp_valid     <= 1'b0;
      r_rsp_data      <= '0;
      r_rsp_timeout   <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_wdog          <= w_wdog_nxt;
      r_key_cached    <= w_key_cached_nxt;
      r_cached_key    <= w_cached_key_nxt;
      r_cached_keylen <= w_cached_keylen_nxt;
      r_cmd_ready     <= w_cmd_ready_nxt;
      r_core_init     <= w_core_init_nxt;
      r_core_next     <= w_core_next_nxt;
      r_core_key      <= w_core_key_nxt;
      r_core_keylen   <= w_core_keylen_nxt;
      r_core_encdec   <= w_core_encdec_nxt;
      r_core_block    <= w_core_block_nxt;
      r_rsp_valid     <= w_rsp_valid_nxt;
      r_rsp_data      <= w_rsp_data_nxt;
      r_rsp_timeout   <= w_rsp_timeout_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    w_state_nxt = r_state;
    w_timeout   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_nxt = w_hit ? S_NEXT_PULSE : S_INIT_PULSE;
      end
      S_INIT_PULSE: begin
        if (core_ready)    w_state_nxt = S_INIT_WAIT;
        else if (w_expire) w_timeout   = 1'b1;
      end
      S_INIT_WAIT: begin
        if (!w_pulse_inflight && core_ready) w_state_nxt = S_NEXT_PULSE;
        else if (w_expire)                   w_timeout   = 1'b1;
      end
      S_NEXT_PULSE: begin
        if (core_ready)    w_state_nxt = S_NEXT_WAIT;
        else if (w_expire) w_timeout   = 1'b1;
      end
      S_NEXT_WAIT: begin
        if (w_result)      w_state_nxt = S_RESP;
        else if (w_expire) w_timeout   = 1'b1;
      end
      S_RESP: begin
        if (bus.rsp_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_timeout) w_state_nxt = S_RESP;
  end

  // Next values of the registered outputs, key cache and watchdog.
  always_comb begin
    w_cmd_ready_nxt     = (w_state_nxt == S_IDLE);
    // Pulses are raised only when the core is idle; they last one cycle
    // because the state moves on in the same edge.
    w_core_init_nxt     = (r_state == S_INIT_PULSE) && core_ready;
    w_core_next_nxt     = (r_state == S_NEXT_PULSE) && core_ready;
    w_core_key_nxt      = r_core_key;
    w_core_keylen_nxt   = r_core_keylen;
    w_core_encdec_nxt   = r_core_encdec;
    w_core_block_nxt    = r_core_block;
    w_key_cached_nxt    = r_key_cached;
    w_cached_key_nxt    = r_cached_key;
    w_cached_keylen_nxt = r_cached_keylen;
    w_rsp_valid_nxt     = r_rsp_valid;
    w_rsp_data_nxt      = r_rsp_data;
    w_rsp_timeout_nxt   = r_rsp_timeout;

    if (w_accept) begin
      w_core_key_nxt    = bus.cmd_key;
      w_core_keylen_nxt = bus.cmd_keylen;
      w_core_encdec_nxt = bus.cmd_encdec;
      w_core_block_nxt  = bus.cmd_block;
      if (!w_hit) begin
        // The core's expanded key is about to be replaced; it only becomes
        // valid again once init completes.
        w_key_cached_nxt    = 1'b0;
        w_cached_key_nxt    = bus.cmd_key;
        w_cached_keylen_nxt = bus.cmd_keylen;
      end
    end

    if (r_state == S_INIT_WAIT && w_state_nxt == S_NEXT_PULSE)
      w_key_cached_nxt = 1'b1;

    if (w_timeout) begin
      // A hung core may hold a half-expanded key, so the cache is dropped.
      w_key_cached_nxt  = 1'b0;
      w_rsp_valid_nxt   = 1'b1;
      w_rsp_data_nxt    = '0;
      w_rsp_timeout_nxt = 1'b1;
    end else if (w_result) begin
      w_rsp_valid_nxt   = 1'b1;
      w_rsp_data_nxt    = core_result;
      w_rsp_timeout_nxt = 1'b0;
    end

    if (r_state == S_RESP && bus.rsp_ready) w_rsp_valid_nxt = 1'b0;

    // Watchdog: cleared on every state change, counts (saturating) while
    // sitting in a pulse/wait state.
    if (w_state_nxt != r_state)
      w_wdog_nxt = '0;
    else if ((r_state inside {S_INIT_PULSE, S_INIT_WAIT, S_NEXT_PULSE, S_NEXT_WAIT}) &&
             (r_wdog != WD_MAX))
      w_wdog_nxt = r_wdog + CNT_W'(1);
    else
      w_wdog_nxt = r_wdog;
  end

  assign bus.cmd_ready   = r_cmd_ready;
  assign bus.rsp_valid   = r_rsp_valid;
  assign bus.rsp_data    = r_rsp_data;
  assign bus.rsp_timeout = r_rsp_timeout;
  assign core_init       = r_core_init;
  assign core_next       = r_core_next;
  assign core_key        = r_core_key;
  assign core_keylen     = r_core_keylen;
  assign core_encdec     = r_core_encdec;
  assign core_block      = r_core_block;

endmodule
